// File: rtl/dac_frame_scheduler.sv
// Feeds a 24-bit DAC SPI master: buffers channel/sample pairs, paces them on a
// programmable tick and tracks frame completion through the master's sync_n.
module dac_frame_scheduler #(
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 4,
  parameter logic [3:0]  CMD        = 4'b0011,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DIV_W      = 16,
  parameter int          TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              rate_div,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  input  logic [ADDR_W-1:0]             s_chan,
  output logic [23:0]                   frame,
  output logic                          spi_en,
  input  logic                          spi_sync_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    underrun_cnt,
  output logic [7:0]                    late_cnt,
  output logic                          timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 2);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_HIGH} state_t;

  state_t                     state, state_nx;
  logic [ADDR_W+DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic                       full, empty, push, pop;
  logic [DIV_W-1:0]           div_cnt;
  logic                       tick, tick_ok, pending;
  logic [TO_W-1:0]            wait_cnt;
  logic                       timeout_hit;

  assign full        = (fifo_level == LVL_FULL);
  assign empty       = (fifo_level == '0);
  assign s_ready     = !full;
  assign push        = s_valid && !full;
  assign pop         = (state == LOAD);
  assign tick        = enable && (div_cnt == '0);
  assign tick_ok     = tick && !empty;
  assign busy        = (state != IDLE);
  assign spi_en      = (state == START);
  assign timeout_hit = (state == START) && spi_sync_n && (wait_cnt == TO_MAX);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_chan, s_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Rate divider plus the pending flag that remembers one unserved tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      pending      <= 1'b0;
      underrun_cnt <= '0;
      late_cnt     <= '0;
    end else begin
      if (!enable) begin
        div_cnt <= '0;
        pending <= 1'b0;
      end else begin
        div_cnt <= (div_cnt == '0) ? rate_div : div_cnt - DIV_W'(1);
        if (state == LOAD)
          pending <= tick_ok;
        else if (tick_ok)
          pending <= 1'b1;
        if (tick_ok && pending && state != LOAD && late_cnt != 8'hFF)
          late_cnt <= late_cnt + 8'd1;
        if (tick && empty && underrun_cnt != 8'hFF)
          underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame       <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        frame    <= {CMD, mem[rd_ptr]};
        wait_cnt <= '0;
      end else if (state == START) begin
        wait_cnt <= wait_cnt + TO_W'(1);
      end
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  // A fresh tick may launch directly from IDLE so spi_en rises two clocks after it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if ((pending || tick_ok) && !empty && spi_sync_n) state_nx = LOAD;
      LOAD:      state_nx = START;
      START:     if (!spi_sync_n) state_nx = WAIT_HIGH;
                 else if (timeout_hit) state_nx = IDLE;
      WAIT_HIGH: if (spi_sync_n) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler with a behavioural SPI master and a
// scoreboard queue of expected frames checked whenever spi_en rises.
module tb_dac_frame_scheduler;

  localparam int TIMEOUT   = 15;
  localparam int FRAME_LOW = 26;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] rate_div = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [3:0]  s_chan = '0;
  logic [23:0] frame;
  logic        spi_en;
  logic        spi_sync_n;
  logic        busy;
  logic [3:0]  fifo_level;
  logic [7:0]  underrun_cnt;
  logic [7:0]  late_cnt;
  logic        timeout_err;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] expq[$];

  logic        connected = 1'b1;
  logic        m_active;
  int          m_cnt;
  int          frames_started = 0;

  logic        mon_prev = 1'b0;
  int          mon_run = 0;
  logic [23:0] mon_exp = '0;

  dac_frame_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rate_div(rate_div),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan),
    .frame(frame), .spi_en(spi_en), .spi_sync_n(spi_sync_n), .busy(busy),
    .fifo_level(fifo_level), .underrun_cnt(underrun_cnt), .late_cnt(late_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Master model: starts on spi_en while idle, holds sync_n low for FRAME_LOW clocks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_sync_n <= 1'b1;
      m_active   <= 1'b0;
      m_cnt      <= 0;
    end else if (m_active) begin
      if (m_cnt == FRAME_LOW - 1) begin
        m_active   <= 1'b0;
        spi_sync_n <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (spi_en && connected) begin
      m_active       <= 1'b1;
      spi_sync_n     <= 1'b0;
      m_cnt          <= 0;
      frames_started <= frames_started + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic expireCheck(input string name, input int n, input int limit);
    checks++;
    if (n >= limit) begin
      errors++;
      $display("[TB] FAIL %s: waited %0d cycles, required under %0d", name, n, limit);
    end
  endtask

  // Monitor: pops the scoreboard on each spi_en rise and checks pulse width.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0;
      mon_run  = 0;
    end else begin
      if (spi_en && !mon_prev) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame: actual %0h, required no frame", frame);
        end else begin
          mon_exp = expq.pop_front();
          checkOutput("frame_order", {8'h0, frame}, {8'h0, mon_exp});
        end
        mon_run = 1;
      end else if (spi_en) begin
        mon_run++;
        checkOutput("frame_held", {8'h0, frame}, {8'h0, mon_exp});
      end else if (mon_prev) begin
        checkOutput("spi_en_width", mon_run, connected ? 2 : TIMEOUT + 1);
      end
      mon_prev = spi_en;
    end
  end

  task automatic applyStimulus(input logic [3:0] chan, input logic [15:0] data);
    @(negedge clk);
    s_valid = 1'b1;
    s_chan  = chan;
    s_data  = data;
    expq.push_back({4'h3, chan, data});
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic applyReset();
    checkOutput("queue_drained", expq.size(), 0);
    rst_n     = 1'b0;
    enable    = 1'b0;
    s_valid   = 1'b0;
    connected = 1'b1;
    expq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitFrameStart(input int limit);
    int n = 0;
    while (spi_en !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    while (spi_en !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    expireCheck("frame_start_wait", n, limit);
  endtask

  task automatic waitBusyLow(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    expireCheck("busy_low_wait", n, limit);
  endtask

  initial begin
    int base;
    int n;
    logic [15:0] d;

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_frame", {8'h0, frame}, 32'h0);
    checkOutput("rst_spi_en", spi_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_underrun", underrun_cnt, 0);
    checkOutput("rst_late", late_cnt, 0);
    checkOutput("rst_timeout", timeout_err, 0);

    // Single frame with two-clock latency
    $display("[TB] single frame");
    applyStimulus(4'd2, 16'hABCD);
    checkOutput("t1_level", fifo_level, 1);
    base     = frames_started;
    rate_div = 16'd99;
    enable   = 1'b1;
    @(negedge clk);
    checkOutput("t1_en_early", spi_en, 0);
    @(negedge clk);
    checkOutput("t1_en_latency", spi_en, 1);
    checkOutput("t1_frame", {8'h0, frame}, 32'h0032ABCD);
    waitBusyLow(100);
    repeat (10) @(negedge clk);
    checkOutput("t1_frame_kept", {8'h0, frame}, 32'h0032ABCD);
    checkOutput("t1_frames", frames_started - base, 1);
    checkOutput("t1_level_end", fifo_level, 0);
    checkOutput("t1_underrun", underrun_cnt, 0);
    enable = 1'b0;

    // Eight samples in FIFO order
    $display("[TB] full fifo, slow rate");
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus(4'(i + 8), 16'h1000 + 16'(i) * 16'h0111);
    checkOutput("t2_full_level", fifo_level, 8);
    checkOutput("t2_s_ready", s_ready, 0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("t2_no_overfill", fifo_level, 8);
    rate_div = 16'd199;
    enable   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      waitFrameStart(400);
      checkOutput("t2_level_count", fifo_level, 7 - k);
    end
    waitBusyLow(100);
    checkOutput("t2_late", late_cnt, 0);
    checkOutput("t2_underrun", underrun_cnt, 0);
    enable = 1'b0;

    // Fast ticks: frames back to back, late ticks counted
    $display("[TB] full fifo, fast rate");
    applyReset();
    for (int i = 0; i < 8; i++) begin
      d = 16'hF0F0 ^ 16'(i * 37);
      applyStimulus(4'(15 - i), d);
    end
    base     = frames_started;
    rate_div = 16'd9;
    enable   = 1'b1;
    n = 0;
    while ((fifo_level != 0 || busy) && n < 2000) begin @(negedge clk); n++; end
    expireCheck("t3_drain_wait", n, 2000);
    enable = 1'b0;
    checkOutput("t3_frames", frames_started - base, 8);
    checkOutput("t3_late_seen", late_cnt != 0, 1);

    // Underruns with an empty FIFO, then saturation
    $display("[TB] underrun");
    applyReset();
    rate_div = 16'd3;
    enable   = 1'b1;
    repeat (18) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("t4_underrun5", underrun_cnt, 5);
    rate_div = 16'd0;
    enable   = 1'b1;
    repeat (260) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("t4_underrun_sat", underrun_cnt, 255);
    checkOutput("t4_busy", busy, 0);

    // Master disconnected: handshake timeout
    $display("[TB] timeout");
    applyReset();
    connected = 1'b0;
    applyStimulus(4'd5, 16'h1234);
    rate_div = 16'd999;
    enable   = 1'b1;
    waitFrameStart(20);
    n = 0;
    while (spi_en && n < 40) begin @(negedge clk); n++; end
    expireCheck("t5_en_fall_wait", n, 40);
    checkOutput("t5_timeout_err", timeout_err, 1);
    checkOutput("t5_busy", busy, 0);
    repeat (5) @(negedge clk);
    checkOutput("t5_sticky", timeout_err, 1);
    enable = 1'b0;

    // Asynchronous reset during WAIT_HIGH, then a clean frame
    $display("[TB] reset mid frame");
    applyReset();
    applyStimulus(4'd1, 16'h5555);
    applyStimulus(4'd3, 16'h7777);
    rate_div = 16'd999;
    enable   = 1'b1;
    waitFrameStart(20);
    n = 0;
    while (spi_en && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checkOutput("t6_in_wait_high", busy, 1);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("t6_rst_frame", {8'h0, frame}, 32'h0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_level", fifo_level, 0);
    checkOutput("t6_rst_s_ready", s_ready, 1);
    checkOutput("t6_rst_spi_en", spi_en, 0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    base = frames_started;
    applyStimulus(4'd7, 16'hBEEF);
    enable = 1'b1;
    waitFrameStart(20);
    waitBusyLow(100);
    enable = 1'b0;
    checkOutput("t6_frame", {8'h0, frame}, 32'h0037BEEF);
    checkOutput("t6_frames", frames_started - base, 1);
    checkOutput("t6_timeout", timeout_err, 0);
    checkOutput("t6_queue_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
